// File: rtl/add_sub_pkg.sv
// Shared types and constants for the add_sub kernel compute stage.
// Saturation limit helpers are constant functions evaluated per DataWidth.
package add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } add_sub_state_t;

    localparam logic ADD_SUB_OP_ADD = 1'b0;
    localparam logic ADD_SUB_OP_SUB = 1'b1;

    // Largest positive two's-complement value of the given width (width <= 128).
    function automatic logic [127:0] add_sub_sat_max(input int unsigned width);
        return (128'd1 << (width - 1)) - 128'd1;
    endfunction

    // Bit pattern of the most negative value, valid in the low `width` bits.
    function automatic logic [127:0] add_sub_sat_min(input int unsigned width);
        return 128'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/add_sub_alu.sv
// Combinational signed add/subtract with overflow detect.
// ADD_SUB_SAT_EN defined: overflowing results clamp and ovf reports them; otherwise results wrap and ovf is 0.
module add_sub_alu
    import add_sub_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [DataWidth-1:0] a,
    input  logic [DataWidth-1:0] b,
    input  logic                 op,
    output logic [DataWidth-1:0] result,
    output logic                 ovf
);

`ifdef ADD_SUB_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    localparam logic [DataWidth-1:0] SatMax = DataWidth'(add_sub_sat_max(DataWidth));
    localparam logic [DataWidth-1:0] SatMin = DataWidth'(add_sub_sat_min(DataWidth));

    logic [DataWidth:0] a_ext;
    logic [DataWidth:0] b_ext;
    logic [DataWidth:0] sum_ext;
    logic               ovf_raw;

    assign a_ext   = {a[DataWidth-1], a};
    assign b_ext   = {b[DataWidth-1], b};
    assign sum_ext = (op == ADD_SUB_OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    assign ovf_raw = sum_ext[DataWidth] ^ sum_ext[DataWidth-1];

    always_comb begin
        result = sum_ext[DataWidth-1:0];
        ovf    = 1'b0;
        if (SatEn && ovf_raw) begin
            ovf    = 1'b1;
            // The extra sign bit still holds the true sign of the result.
            result = sum_ext[DataWidth] ? SatMin : SatMax;
        end
    end

endmodule

// File: rtl/add_sub_stream_core.sv
// add_sub kernel compute stage: joins A/B streams, adds or subtracts each pair, one-entry output register.
// Saturation is enabled by defining ADD_SUB_SAT_EN; default build wraps and ties ovf low.
module add_sub_stream_core
    import add_sub_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int LenWidth  = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    input  logic [LenWidth-1:0]  len,
    input  logic                 op,
    output logic                 ap_idle,
    output logic                 ap_ready,
    output logic                 ap_done,
    input  logic [DataWidth-1:0] a_data,
    input  logic                 a_vld,
    output logic                 a_ack,
    input  logic [DataWidth-1:0] b_data,
    input  logic                 b_vld,
    output logic                 b_ack,
    output logic [DataWidth-1:0] r_data,
    output logic                 r_vld,
    input  logic                 r_ack,
    output logic                 ovf
);

    add_sub_state_t       state;
    add_sub_state_t       state_nxt;
    logic [LenWidth-1:0]  remaining;
    logic                 op_q;
    logic                 fire;
    logic                 start;
    logic [DataWidth-1:0] alu_result;
    logic                 alu_ovf;

    add_sub_alu #(
        .DataWidth(DataWidth)
    ) u_alu (
        .a      (a_data),
        .b      (b_data),
        .op     (op_q),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ap_idle   = 1'b0;
        ap_ready  = 1'b0;
        ap_done   = 1'b0;
        fire      = 1'b0;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    start     = 1'b1;
                    ap_ready  = 1'b1;
                    state_nxt = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                fire = (remaining != '0) && a_vld && b_vld && (!r_vld || r_ack);
                // Leave as the last result is taken so ap_done lands right after that handshake.
                if ((remaining == '0) && (!r_vld || r_ack)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                ap_done   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign a_ack = fire;
    assign b_ack = fire;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            remaining <= '0;
            op_q      <= ADD_SUB_OP_ADD;
            ovf       <= 1'b0;
            r_data    <= '0;
            r_vld     <= 1'b0;
        end else begin
            if (start) begin
                remaining <= len;
                op_q      <= op;
                ovf       <= 1'b0;
            end else if (fire) begin
                remaining <= remaining - LenWidth'(1);
                if (alu_ovf) begin
                    ovf <= 1'b1;
                end
            end
            if (fire) begin
                r_data <= alu_result;
                r_vld  <= 1'b1;
            end else if (r_ack) begin
                r_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_add_sub_stream_core.sv
// Self-checking bench for add_sub_stream_core: directed scenarios plus randomized transfers vs an arithmetic model.
module tb_add_sub_stream_core;

`ifdef ADD_SUB_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ap_start = 1'b0;
    logic [15:0] len = '0;
    logic        op = 1'b0;
    logic        ap_idle, ap_ready, ap_done;
    logic [31:0] a_data = '0;
    logic        a_vld = 1'b0;
    logic        a_ack;
    logic [31:0] b_data = '0;
    logic        b_vld = 1'b0;
    logic        b_ack;
    logic [31:0] r_data;
    logic        r_vld;
    logic        r_ack = 1'b0;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    logic [31:0] r_got[$];
    int s_ready, s_timeout, s_viol, s_acks, s_done_gap, s_first_hs, s_last_hs, s_idle_after;
    logic s_ovf;

    always #5 ap_clk = ~ap_clk;

    add_sub_stream_core #(
        .DataWidth(32),
        .LenWidth (16)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .len      (len),
        .op       (op),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .ap_done  (ap_done),
        .a_data   (a_data),
        .a_vld    (a_vld),
        .a_ack    (a_ack),
        .b_data   (b_data),
        .b_vld    (b_vld),
        .b_ack    (b_ack),
        .r_data   (r_data),
        .r_vld    (r_vld),
        .r_ack    (r_ack),
        .ovf      (ovf)
    );

    function automatic longint exact(input logic [31:0] a, input logic [31:0] b, input bit sub);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        return sub ? (sa - sb) : (sa + sb);
    endfunction

    function automatic bit model_ovf(input logic [31:0] a, input logic [31:0] b, input bit sub);
        longint s = exact(a, b, sub);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] model_r(input logic [31:0] a, input logic [31:0] b, input bit sub);
        longint s = exact(a, b, sub);
        if (SatEn && s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (SatEn && s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    // Drives one transfer from a_q/b_q and records results and protocol observations; no checks here.
    task automatic run_stream(input int n, input bit opv, input int av_pct, input int bv_pct,
                              input int ack_pct, input int hold_lo, input int hold_hi);
        int ai = 0;
        bit done = 1'b0;
        bit prev_hold = 1'b0;
        logic [31:0] prev_data = '0;
        r_got.delete();
        s_viol = 0; s_acks = 0; s_done_gap = -1; s_first_hs = -1; s_last_hs = 0;
        @(posedge ap_clk); #1;
        ap_start = 1'b1; len = n[15:0]; op = opv;
        a_vld = 1'b0; b_vld = 1'b0; r_ack = 1'b0;
        #1;
        s_ready = int'(ap_ready);
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        for (int cyc = 1; cyc < 3000 && !done; cyc++) begin
            a_vld  = (ai < n) && ($urandom_range(99) < av_pct);
            b_vld  = (ai < n) && ($urandom_range(99) < bv_pct);
            a_data = (ai < n) ? a_q[ai] : $urandom;
            b_data = (ai < n) ? b_q[ai] : $urandom;
            r_ack  = (cyc >= hold_lo && cyc <= hold_hi) ? 1'b0 : ($urandom_range(99) < ack_pct);
            #1;
            if (ap_done) begin
                done = 1'b1;
                s_done_gap = cyc - s_last_hs;
            end
            if (a_ack !== b_ack) s_viol++;
            if (a_ack && !(a_vld && b_vld)) s_viol++;
            if (r_vld && !r_ack && a_ack) s_viol++;
            if (prev_hold && (r_vld !== 1'b1 || r_data !== prev_data)) s_viol++;
            if (a_ack) begin
                ai++;
                s_acks++;
            end
            if (r_vld && r_ack) begin
                r_got.push_back(r_data);
                if (s_first_hs < 0) s_first_hs = cyc;
                s_last_hs = cyc;
            end
            prev_hold = r_vld && !r_ack;
            prev_data = r_data;
            @(posedge ap_clk); #1;
        end
        s_timeout    = done ? 0 : 1;
        s_idle_after = int'(ap_idle && !ap_done);
        s_ovf        = ovf;
        a_vld = 1'b0; b_vld = 1'b0; r_ack = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        a_vld = 1'b1; b_vld = 1'b1; r_ack = 1'b1;
        #13;
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", ap_idle); end
        checks++; if (ap_ready !== 1'b0 || ap_done !== 1'b0) begin errors++; $display("FAIL reset_ready_done: got %b%b want 00", ap_ready, ap_done); end
        checks++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin errors++; $display("FAIL reset_acks: got %b%b want 00", a_ack, b_ack); end
        checks++; if (r_vld !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_vld_ovf: got %b%b want 00", r_vld, ovf); end
        checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", r_data); end
        a_vld = 1'b0; b_vld = 1'b0; r_ack = 1'b0;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
    endtask

    task automatic test_basic();
        a_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        b_q = '{32'd10, 32'd20, 32'd30, 32'd40};
        run_stream(4, 1'b0, 100, 100, 100, 0, -1);
        checks++; if (s_ready !== 1) begin errors++; $display("FAIL basic_ready: got %0d want 1", s_ready); end
        checks++; if (s_timeout !== 0) begin errors++; $display("FAIL basic_timeout: got %0d want 0", s_timeout); end
        checks++; if (r_got.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d want 4", r_got.size()); end
        for (int i = 0; i < r_got.size() && i < 4; i++) begin
            checks++;
            if (r_got[i] !== model_r(a_q[i], b_q[i], 1'b0)) begin
                errors++; $display("FAIL basic_r[%0d]: got %0d want %0d", i, r_got[i], model_r(a_q[i], b_q[i], 1'b0));
            end
        end
        checks++; if (s_first_hs !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", s_first_hs); end
        checks++; if (s_last_hs - s_first_hs !== 3) begin errors++; $display("FAIL basic_throughput: got %0d want 3", s_last_hs - s_first_hs); end
        checks++; if (s_done_gap !== 1) begin errors++; $display("FAIL basic_done_gap: got %0d want 1", s_done_gap); end
        checks++; if (s_idle_after !== 1) begin errors++; $display("FAIL basic_done_pulse: got %0d want 1", s_idle_after); end
        checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", s_ovf); end
    endtask

    task automatic test_sub();
        a_q = '{32'd5};
        b_q = '{32'd7};
        run_stream(1, 1'b1, 100, 100, 100, 0, -1);
        checks++; if (r_got.size() !== 1 || r_got[0] !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL sub_r: got n=%0d %h want FFFFFFFE", r_got.size(), r_got.size() ? r_got[0] : 32'hx);
        end
        checks++; if (s_done_gap !== 1 || s_timeout !== 0) begin errors++; $display("FAIL sub_done: got gap=%0d to=%0d want 1 0", s_done_gap, s_timeout); end
    endtask

    task automatic test_backpressure();
        a_q.delete(); b_q.delete();
        for (int i = 0; i < 8; i++) begin a_q.push_back($urandom); b_q.push_back($urandom); end
        run_stream(8, 1'b0, 100, 100, 100, 3, 7);
        checks++; if (s_viol !== 0) begin errors++; $display("FAIL bp_protocol: got %0d violations want 0", s_viol); end
        checks++; if (r_got.size() !== 8 || s_acks !== 8) begin errors++; $display("FAIL bp_count: got r=%0d acks=%0d want 8 8", r_got.size(), s_acks); end
        for (int i = 0; i < r_got.size() && i < 8; i++) begin
            checks++;
            if (r_got[i] !== model_r(a_q[i], b_q[i], 1'b0)) begin
                errors++; $display("FAIL bp_r[%0d]: got %h want %h", i, r_got[i], model_r(a_q[i], b_q[i], 1'b0));
            end
        end
    endtask

    task automatic test_pairing();
        a_q.delete(); b_q.delete();
        for (int i = 0; i < 10; i++) begin a_q.push_back($urandom); b_q.push_back($urandom); end
        run_stream(10, 1'b1, 100, 50, 100, 0, -1);
        checks++; if (s_viol !== 0) begin errors++; $display("FAIL pair_protocol: got %0d violations want 0", s_viol); end
        checks++; if (r_got.size() !== 10) begin errors++; $display("FAIL pair_count: got %0d want 10", r_got.size()); end
        for (int i = 0; i < r_got.size() && i < 10; i++) begin
            checks++;
            if (r_got[i] !== model_r(a_q[i], b_q[i], 1'b1)) begin
                errors++; $display("FAIL pair_r[%0d]: got %h want %h", i, r_got[i], model_r(a_q[i], b_q[i], 1'b1));
            end
        end
    endtask

    task automatic test_overflow();
        a_q = '{32'h7FFF_FFFF};
        b_q = '{32'h0000_0001};
        run_stream(1, 1'b0, 100, 100, 100, 0, -1);
        checks++; if (r_got.size() !== 1 || r_got[0] !== (SatEn ? 32'h7FFF_FFFF : 32'h8000_0000)) begin
            errors++; $display("FAIL ovf_r: got n=%0d %h want %h", r_got.size(), r_got.size() ? r_got[0] : 32'hx, SatEn ? 32'h7FFF_FFFF : 32'h8000_0000);
        end
        checks++; if (s_ovf !== SatEn) begin errors++; $display("FAIL ovf_flag: got %b want %b", s_ovf, SatEn); end
    endtask

    task automatic test_len0();
        a_q.delete(); b_q.delete();
        run_stream(0, 1'b0, 100, 100, 100, 0, -1);
        checks++; if (s_ready !== 1) begin errors++; $display("FAIL len0_ready: got %0d want 1", s_ready); end
        checks++; if (s_done_gap !== 1) begin errors++; $display("FAIL len0_done_gap: got %0d want 1", s_done_gap); end
        checks++; if (s_acks !== 0 || r_got.size() !== 0) begin errors++; $display("FAIL len0_activity: got acks=%0d r=%0d want 0 0", s_acks, r_got.size()); end
        checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL len0_ovf_cleared: got %b want 0", s_ovf); end
    endtask

    task automatic test_rst_mid();
        @(posedge ap_clk); #1;
        ap_start = 1'b1; len = 16'd4; op = 1'b0; r_ack = 1'b0;
        @(posedge ap_clk); #1;
        ap_start = 1'b0; a_vld = 1'b1; b_vld = 1'b1; a_data = 32'd5; b_data = 32'd6;
        @(posedge ap_clk); #1;
        a_vld = 1'b0; b_vld = 1'b0;
        checks++; if (r_vld !== 1'b1 || r_data !== 32'd11) begin errors++; $display("FAIL rstmid_pending: got vld=%b %0d want 1 11", r_vld, r_data); end
        #2 ap_rst = 1'b1;
        #1;
        checks++; if (r_vld !== 1'b0 || ap_idle !== 1'b1) begin errors++; $display("FAIL rstmid_async: got vld=%b idle=%b want 0 1", r_vld, ap_idle); end
        checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h want 0", r_data); end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] edges [4];
        edges[0] = 32'h7FFF_FFFF; edges[1] = 32'h8000_0000; edges[2] = 32'hFFFF_FFFF; edges[3] = 32'h0;
        for (int t = 0; t < 6; t++) begin
            int n = $urandom_range(12, 1);
            bit opv = $urandom_range(1);
            bit any_ovf = 1'b0;
            int bad = 0;
            a_q.delete(); b_q.delete();
            for (int i = 0; i < n; i++) begin
                a_q.push_back(($urandom_range(3) == 0) ? edges[$urandom_range(3)] : $urandom);
                b_q.push_back(($urandom_range(3) == 0) ? edges[$urandom_range(3)] : $urandom);
                any_ovf |= model_ovf(a_q[i], b_q[i], opv);
            end
            run_stream(n, opv, $urandom_range(100, 40), $urandom_range(100, 40), $urandom_range(100, 30), 0, -1);
            checks++; if (s_timeout !== 0 || r_got.size() !== n) begin errors++; $display("FAIL rand%0d_count: got r=%0d to=%0d want %0d 0", t, r_got.size(), s_timeout, n); end
            for (int i = 0; i < r_got.size() && i < n; i++) begin
                if (r_got[i] !== model_r(a_q[i], b_q[i], opv)) bad++;
            end
            checks++; if (bad !== 0) begin errors++; $display("FAIL rand%0d_data: got %0d wrong results want 0", t, bad); end
            checks++; if (s_viol !== 0 || s_done_gap !== 1) begin errors++; $display("FAIL rand%0d_protocol: got viol=%0d gap=%0d want 0 1", t, s_viol, s_done_gap); end
            checks++; if (s_ovf !== (SatEn & any_ovf)) begin errors++; $display("FAIL rand%0d_ovf: got %b want %b", t, s_ovf, SatEn & any_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sub();
        test_backpressure();
        test_pairing();
        test_overflow();
        test_len0();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
